// File: rtl/filter_pkg.sv
// Shared constants for the FIR output path: default sample widths and
// saturation limits expressed as functions of the output width.
package filter_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int OUT_MAX = sat_max(OUT_W_DEF);
  localparam int OUT_MIN = sat_min(OUT_W_DEF);

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; a write while full is accepted when a read
// pops the head in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_fire, rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign rd_fire = rd_en && !empty;
  assign wr_fire = wr_en && (!full || rd_fire);

  // Head forced to zero when empty so reset and idle read as 0.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/filter_out_buffer.sv
// FIR output requantizer (shift, optional round, saturate) feeding a
// show-ahead FIFO with sticky drop flag. Rounding: define FILTER_OUT_ROUND_EN.
module filter_out_buffer
  import filter_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

`ifdef FILTER_OUT_ROUND_EN
  localparam logic signed [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);
`else
  localparam logic signed [IN_W:0] RND = '0;
`endif
  localparam logic signed [IN_W:0] MAX_T = (IN_W + 1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0] MIN_T = (IN_W + 1)'(sat_min(OUT_W));

  logic signed [IN_W:0] t, sh;
  logic [OUT_W-1:0]     sat;
  logic [OUT_W-1:0]     s_q, s_d;
  logic                 q_v_q, q_v_d;
  logic                 ovf_q, ovf_d;
  logic                 fifo_full, fifo_empty, drop;

  always_comb begin
    // One guard bit keeps in_data + R from wrapping at the positive limit.
    t  = {in_data[IN_W-1], in_data} + RND;
    sh = t >>> SHIFT;
    if (sh > MAX_T)      sat = MAX_T[OUT_W-1:0];
    else if (sh < MIN_T) sat = MIN_T[OUT_W-1:0];
    else                 sat = sh[OUT_W-1:0];
    s_d   = in_valid ? sat : s_q;
    q_v_d = in_valid;
  end

  assign drop = q_v_q && fifo_full && !(out_valid && out_ready);

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_q   <= '0;
      q_v_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      q_v_q <= q_v_d;
      ovf_q <= ovf_d;
    end
  end

  sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (q_v_q),
    .wr_data (s_q),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign ovf       = ovf_q;

endmodule

// File: doc/filter_out_buffer.md
# filter_out_buffer

Output-side companion to the 8-tap FIR filter: accepts the filter's 16-bit signed sample stream, requantizes each sample to OUT_W bits (arithmetic right shift, optional rounding, saturation) and buffers results in a small FIFO. The FIFO presents them to a downstream consumer over a valid/ready handshake. It sits between the filter's `y_n` output and any slower sink, and flags samples lost to back-pressure.

## Interface
- `IN_W`, 16, input sample width (two's complement)
- `OUT_W`, 8, output sample width (two's complement)
- `SHIFT`, 8, arithmetic right shift applied before saturation; 1..IN_W-1
- `DEPTH`, 8, FIFO entries; power of two, ≥2

- `clk`  in  1  sole clock; all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `in_valid`  in  1  `in_data` carries a sample this cycle
- `in_data`  in  IN_W  signed filter output sample
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  OUT_W  signed requantized sample at FIFO head
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `ovf`  out  1  sticky: a sample was dropped
- `ovf_clr`  in  1  synchronous clear of `ovf`

## Operation
- Stage Q (quantizer register): on `in_valid`, compute `t = in_data + R` in IN_W+1 bits, where R = 2^(SHIFT-1) if rounding is enabled, else 0. Then `s = t >>> SHIFT`, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Register `s` plus a valid bit `q_v`. `q_v` follows `in_valid` each cycle; no input back-pressure, because the filter cannot stall.
- Stage F (FIFO write): when `q_v`=1, write the Q register into the FIFO. The write succeeds if the FIFO is not full, or if it is full and a read happens in the same cycle (`out_valid && out_ready`).
- Drop: `q_v`=1, FIFO full and no read → sample discarded, FIFO unchanged, `ovf` set.
- Read: `out_valid && out_ready` pops the head. `out_ready` while empty has no effect.
- Show-ahead FIFO: `out_data` is the head whenever `out_valid`=1. Value is don't-care when empty, but it is held stable while `out_valid && !out_ready`.
- `count` = entries held. Simultaneous write and read leaves `count` unchanged. Pointers wrap modulo DEPTH.
- `ovf`: a drop sets it; `ovf_clr` clears it. If both occur in the same cycle, the set wins.

## Timing
- Reset (async assert, sync release by the system): `out_valid`=0, `out_data`=0, `count`=0, `ovf`=0, `q_v`=0, Q register=0, pointers=0.
- Reset mid-stream: all buffered and in-flight samples are discarded. The first sample after release follows normal latency.
- Latency with an empty FIFO: `in_valid` sampled at edge k → Q loaded at k → FIFO written at edge k+1 → `out_valid`=1 in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: 1 sample/cycle sustained when `out_ready` is held at 1. With `in_valid` and `out_ready` high continuously, `count` stays ≤1.
- `count` and `out_valid` update on the same edge as the write or pop that changes them.

## Configuration
- `FILTER_OUT_ROUND_EN` defined: R = 2^(SHIFT-1), round-half-up (toward +∞ at exact .5).
- Not defined: R = 0, pure truncation (floor). Logic and latency are otherwise identical.

## Structure
- Shared package `filter_pkg`: the IN_W/OUT_W defaults, plus the saturation limit constants OUT_MAX and OUT_MIN as functions of OUT_W.
- Sub-module `sample_fifo`: synchronous show-ahead FIFO, parameters WIDTH and DEPTH. Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty. The write-when-full-with-read rule is implemented inside it.
- Quantizer and overflow logic live in the top module.

## Test plan
- Reset: assert `resetn`=0 mid-burst → all outputs 0 immediately (async); after release, sample 320 appears 2 cycles later as `out_data`=1.
- Quantization (SHIFT=8), with rounding / without:
  - 384 → 2 / 1
  - -384 → -1 / -2
  - 320 → 1 / 1
  - 32767 → 127 / 127 (saturate high)
  - -32768 → -128 / -128 (saturate low)
- Fill/overflow: `out_ready`=0, 10 consecutive samples 1..10 (pre-shift values ×256) → `count`=8, `ovf`=1, outputs drain as 1..8; samples 9 and 10 are lost.
- Full with simultaneous read: FIFO full, one `in_valid` together with `out_ready`=1 → new sample accepted, `count` stays 8, `ovf` stays 0.
- Back-pressure hold: toggle `out_ready` pseudo-randomly while streaming 100 samples → output order matches input, no loss, `out_data` stable while stalled.
- `ovf_clr` asserted in the same cycle as a drop → `ovf` remains 1; asserted alone → `ovf` returns to 0 next cycle.
